hbc_arbiter: RTL and testbench
==============================

HBC_ARBITER -- requirements
Module: hbc_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority with port 0 winning.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have, for each port p in {0,1}, port i_mP_valid, input, 1, request valid.
REQ-005 SHALL have, for each port, port o_mP_ready, output, 1, one-cycle completion pulse.
REQ-006 SHALL have, for each port, port i_mP_cfg_access, input, 1, the configuration-space flag.
REQ-007 SHALL have, for each port, ports i_mP_wstrb (input, 4), i_mP_addr (input, 32) and i_mP_wdata (input, 32): byte strobes, address and write data.
REQ-008 SHALL have, for each port, port o_mP_rdata, output, 32, registered read data.
REQ-009 SHALL have downstream ports o_mem_valid (output, 1), i_mem_ready (input, 1) and o_cfg_access (output, 1), driving the HyperBus controller handshake.
REQ-010 SHALL have downstream ports o_mem_wstrb (output, 4), o_mem_addr (output, 32), o_mem_wdata (output, 32) and i_mem_rdata (input, 32).
REQ-011 SHALL have port o_grant, output, 2, a one-hot indication of the port currently owning the downstream interface.
REQ-012 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, BUSY and RESP.
REQ-014 IDLE: if any i_mP_valid is high, SHALL select a winner, latch its cfg/wstrb/addr/wdata into the downstream registers, set o_grant and go to BUSY on the next edge; otherwise SHALL stay in IDLE.
REQ-015 Round-robin tie (ARB_MODE=0, both valid): SHALL grant the port not granted last; the last-grant pointer updates only at grant.
REQ-016 ARB_MODE=1: port 0 SHALL always win a tie.
REQ-017 Single requester: SHALL be granted regardless of mode or pointer.
REQ-018 o_mem_valid SHALL be registered; it is high throughout BUSY and low in IDLE and RESP.
REQ-019 Downstream address, data, strobe and cfg outputs SHALL be stable for the whole of BUSY.
REQ-020 Latency: a request sampled in IDLE at cycle N SHALL produce o_mem_valid=1 in cycle N+1.
REQ-021 BUSY with i_mem_ready=1 at cycle M SHALL: go to RESP; capture i_mem_rdata into o_mP_rdata of the granted port only when the latched wstrb==0; pulse that port's o_mP_ready in cycle M+1 only.
REQ-022 A write (latched wstrb!=0) SHALL leave o_mP_rdata unchanged.
REQ-023 RESP SHALL last exactly one cycle and SHALL then go to IDLE with o_grant cleared; no new grant is issued in RESP.
REQ-024 Back-to-back: the minimum gap from one o_mem_valid fall to the next rise SHALL be 2 cycles (RESP, IDLE).
REQ-025 A requester dropping valid during BUSY SHALL NOT abort the downstream transfer; the transfer completes and the ready pulse is still issued.
REQ-026 i_mem_ready SHALL be ignored outside BUSY.
REQ-027 o_mP_ready SHALL never be high for both ports in the same cycle.
REQ-028 The non-granted port SHALL see o_mP_ready=0 and unchanged o_mP_rdata.

Reset
REQ-029 i_rstn low SHALL immediately force state=IDLE, o_mem_valid=0, o_cfg_access=0, o_mem_wstrb=0, o_mem_addr=0, o_mem_wdata=0, o_mP_ready=0, o_mP_rdata=0, o_grant=2'b00, o_busy=0, and round-robin pointer = "last granted port 1" (so port 0 wins the first tie).
REQ-030 Reset asserted mid-BUSY SHALL abandon the transfer with no ready pulse; after release the block SHALL start in IDLE.

Verification
REQ-031 Single read: m0 valid, addr=0x0000_0010, wstrb=0; i_mem_ready at BUSY cycle 5 with rdata=0xDEADBEEF -> o_mem_valid high from N+1; o_m0_ready pulse one cycle later; o_m0_rdata=0xDEADBEEF.
REQ-032 Tie, ARB_MODE=0: m0 and m1 held valid -> grants alternate m0, m1, m0, m1; o_grant one-hot; never both ready in the same cycle.
REQ-033 Tie, ARB_MODE=1: both held valid over 3 transfers -> all go to m0 while it stays valid; m1 is granted only after m0 drops.
REQ-034 Write: m1 wstrb=4'b0011, wdata=0x1234_5678 -> downstream fields match and stay stable through BUSY; o_m1_rdata unchanged after o_m1_ready.
REQ-035 Reset mid-BUSY: i_rstn low for 1 cycle -> o_mem_valid=0 immediately; no ready pulse; the next tie grants m0.
REQ-036 Stray ready: i_mem_ready=1 in IDLE and RESP -> no state change and no ready pulse.

Source files
------------

// File: rtl/hbc_arbiter.sv
`default_nettype none
// ============================================================================
// hbc_arbiter : two-master arbiter in front of a HyperBus controller port
// Revision    : 1.0
// ============================================================================
module hbc_arbiter #(
    parameter int ARB_MODE = 0
) (
    input  logic        i_clk,
    input  logic        i_rstn,

    input  logic        i_m0_valid,
    output logic        o_m0_ready,
    input  logic        i_m0_cfg_access,
    input  logic [3:0]  i_m0_wstrb,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_valid,
    output logic        o_m1_ready,
    input  logic        i_m1_cfg_access,
    input  logic [3:0]  i_m1_wstrb,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,

    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic        o_cfg_access,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,

    output logic [1:0]  o_grant,
    output logic        o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic        last_q,      last_d;
    logic        mem_valid_q, mem_valid_d;
    logic        cfg_q,       cfg_d;
    logic [3:0]  wstrb_q,     wstrb_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [1:0]  grant_q,     grant_d;
    logic [1:0]  ready_q,     ready_d;
    logic [31:0] rdata0_q,    rdata0_d;
    logic [31:0] rdata1_q,    rdata1_d;
    logic        w_win;

    always_comb begin
        // w_win = 1 selects port 1; last_q holds the port granted most recently
        w_win = 1'b0;
        if (i_m0_valid && i_m1_valid) begin
            w_win = (ARB_MODE != 0) ? 1'b0 : ~last_q;
        end else begin
            w_win = ~i_m0_valid;
        end

        state_d     = state_q;
        last_d      = last_q;
        mem_valid_d = mem_valid_q;
        cfg_d       = cfg_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        grant_d     = grant_q;
        ready_d     = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (i_m0_valid || i_m1_valid) begin
                    state_d     = ST_BUSY;
                    mem_valid_d = 1'b1;
                    last_d      = w_win;
                    grant_d     = w_win ? 2'b10 : 2'b01;
                    cfg_d       = w_win ? i_m1_cfg_access : i_m0_cfg_access;
                    wstrb_d     = w_win ? i_m1_wstrb      : i_m0_wstrb;
                    addr_d      = w_win ? i_m1_addr       : i_m0_addr;
                    wdata_d     = w_win ? i_m1_wdata      : i_m0_wdata;
                end
            end
            ST_BUSY: begin
                if (i_mem_ready) begin
                    state_d     = ST_RESP;
                    mem_valid_d = 1'b0;
                    ready_d     = grant_q;
                    if (wstrb_q == 4'd0) begin
                        if (grant_q[0]) rdata0_d = i_mem_rdata;
                        if (grant_q[1]) rdata1_d = i_mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
                grant_d     = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            mem_valid_q <= 1'b0;
            cfg_q       <= 1'b0;
            wstrb_q     <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            grant_q     <= 2'b00;
            ready_q     <= 2'b00;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_valid_q <= mem_valid_d;
            cfg_q       <= cfg_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            grant_q     <= grant_d;
            ready_q     <= ready_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign o_mem_valid  = mem_valid_q;
    assign o_cfg_access = cfg_q;
    assign o_mem_wstrb  = wstrb_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_grant      = grant_q;
    assign o_m0_ready   = ready_q[0];
    assign o_m1_ready   = ready_q[1];
    assign o_m0_rdata   = rdata0_q;
    assign o_m1_rdata   = rdata1_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hbc_arbiter.sv
`default_nettype none
// tb_hbc_arbiter : drives a round-robin and a fixed-priority instance with the
// same stimulus and checks both against a transaction-level model.
module tb_hbc_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  vld = 2'b00;
    logic [1:0]  cfg = 2'b00;
    logic [3:0]  p_wstrb [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    // index 0 = ARB_MODE 0 instance, index 1 = ARB_MODE 1 instance
    logic        rdy  [2][2];
    logic [31:0] rd   [2][2];
    logic        mv   [2];
    logic        mcfg [2];
    logic [3:0]  mws  [2];
    logic [31:0] mad  [2];
    logic [31:0] mwd  [2];
    logic [1:0]  gnt  [2];
    logic        bsy  [2];

    int          last_g [2];
    logic [31:0] exp_rd [2][2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    hbc_arbiter #(.ARB_MODE(0)) u_rr (
        .i_clk(clk), .i_rstn(rstn),
        .i_m0_valid(vld[0]), .o_m0_ready(rdy[0][0]), .i_m0_cfg_access(cfg[0]),
        .i_m0_wstrb(p_wstrb[0]), .i_m0_addr(p_addr[0]), .i_m0_wdata(p_wdata[0]),
        .o_m0_rdata(rd[0][0]),
        .i_m1_valid(vld[1]), .o_m1_ready(rdy[0][1]), .i_m1_cfg_access(cfg[1]),
        .i_m1_wstrb(p_wstrb[1]), .i_m1_addr(p_addr[1]), .i_m1_wdata(p_wdata[1]),
        .o_m1_rdata(rd[0][1]),
        .o_mem_valid(mv[0]), .i_mem_ready(mem_ready), .o_cfg_access(mcfg[0]),
        .o_mem_wstrb(mws[0]), .o_mem_addr(mad[0]), .o_mem_wdata(mwd[0]),
        .i_mem_rdata(mem_rdata), .o_grant(gnt[0]), .o_busy(bsy[0])
    );

    hbc_arbiter #(.ARB_MODE(1)) u_fp (
        .i_clk(clk), .i_rstn(rstn),
        .i_m0_valid(vld[0]), .o_m0_ready(rdy[1][0]), .i_m0_cfg_access(cfg[0]),
        .i_m0_wstrb(p_wstrb[0]), .i_m0_addr(p_addr[0]), .i_m0_wdata(p_wdata[0]),
        .o_m0_rdata(rd[1][0]),
        .i_m1_valid(vld[1]), .o_m1_ready(rdy[1][1]), .i_m1_cfg_access(cfg[1]),
        .i_m1_wstrb(p_wstrb[1]), .i_m1_addr(p_addr[1]), .i_m1_wdata(p_wdata[1]),
        .o_m1_rdata(rd[1][1]),
        .o_mem_valid(mv[1]), .i_mem_ready(mem_ready), .o_cfg_access(mcfg[1]),
        .o_mem_wstrb(mws[1]), .o_mem_addr(mad[1]), .o_mem_wdata(mwd[1]),
        .i_mem_rdata(mem_rdata), .o_grant(gnt[1]), .o_busy(bsy[1])
    );

    // Arbitration rule: a lone requester wins; on a tie mode 1 picks port 0,
    // mode 0 picks the port that was not granted last.
    function automatic int winner(input int mode, input int last, input logic [1:0] v);
        if (v == 2'b11) return (mode != 0) ? 0 : 1 - last;
        return v[0] ? 0 : 1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            last_g[d] = 1;
            exp_rd[d][0] = 32'd0;
            exp_rd[d][1] = 32'd0;
        end
    endfunction

    task automatic rand_fields();
        for (int p = 0; p < 2; p++) begin
            p_wstrb[p] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            p_addr[p]  = $urandom;
            p_wdata[p] = $urandom;
            cfg[p]     = 1'($urandom % 2);
        end
    endtask

    // Runs one complete transfer; starts and ends just after a falling edge.
    task automatic do_txn(input logic [1:0] v, input bit drop, input int wait_n,
                          input logic [31:0] rdata_in);
        int w [2];
        logic [3:0]  lw [2];
        logic [31:0] la [2];
        logic [31:0] ld [2];
        logic        lc [2];
        vld = v;
        mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            w[d] = winner(d, last_g[d], v);
            last_g[d] = w[d];
            lw[d] = p_wstrb[w[d]]; la[d] = p_addr[w[d]];
            ld[d] = p_wdata[w[d]]; lc[d] = cfg[w[d]];
            checks++;
            if (mv[d] !== 1'b1 || bsy[d] !== 1'b1) begin
                errors++;
                $display("FAIL grant_valid dut%0d: mem_valid=%b busy=%b want 1 1", d, mv[d], bsy[d]);
            end
            checks++;
            if (gnt[d] !== (2'b01 << w[d])) begin
                errors++;
                $display("FAIL grant dut%0d: got %b want %b", d, gnt[d], 2'b01 << w[d]);
            end
            checks++;
            if (mad[d] !== la[d] || mwd[d] !== ld[d] || mws[d] !== lw[d] || mcfg[d] !== lc[d]) begin
                errors++;
                $display("FAIL fields dut%0d: got %h/%h/%h/%b want %h/%h/%h/%b",
                         d, mad[d], mwd[d], mws[d], mcfg[d], la[d], ld[d], lw[d], lc[d]);
            end
        end
        if (drop) begin
            vld = 2'b00;
            rand_fields();
        end
        repeat (wait_n) begin
            mem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (mv[d] !== 1'b1 || mad[d] !== la[d] || mwd[d] !== ld[d] || mws[d] !== lw[d]
                    || mcfg[d] !== lc[d] || rdy[d][0] !== 1'b0 || rdy[d][1] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_hold dut%0d: valid=%b addr=%h wstrb=%h ready=%b%b want 1 %h %h 00",
                             d, mv[d], mad[d], mws[d], rdy[d][1], rdy[d][0], la[d], lw[d]);
                end
            end
        end
        mem_ready = 1'b1;
        mem_rdata = rdata_in;
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (lw[d] == 4'h0) exp_rd[d][w[d]] = rdata_in;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rdy[d][p] !== (p == w[d])) begin
                    errors++;
                    $display("FAIL ready_pulse dut%0d port%0d: got %b want %b", d, p, rdy[d][p], p == w[d]);
                end
                checks++;
                if (rd[d][p] !== exp_rd[d][p]) begin
                    errors++;
                    $display("FAIL rdata dut%0d port%0d: got %h want %h", d, p, rd[d][p], exp_rd[d][p]);
                end
            end
            checks++;
            if (mv[d] !== 1'b0 || bsy[d] !== 1'b1) begin
                errors++;
                $display("FAIL resp_state dut%0d: mem_valid=%b busy=%b want 0 1", d, mv[d], bsy[d]);
            end
        end
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (gnt[d] !== 2'b00 || bsy[d] !== 1'b0 || mv[d] !== 1'b0
                || rdy[d][0] !== 1'b0 || rdy[d][1] !== 1'b0) begin
                errors++;
                $display("FAIL back_to_idle dut%0d: grant=%b busy=%b valid=%b ready=%b%b want 00 0 0 00",
                         d, gnt[d], bsy[d], mv[d], rdy[d][1], rdy[d][0]);
            end
            checks++;
            if (rd[d][0] !== exp_rd[d][0] || rd[d][1] !== exp_rd[d][1]) begin
                errors++;
                $display("FAIL rdata_hold dut%0d: got %h %h want %h %h",
                         d, rd[d][0], rd[d][1], exp_rd[d][0], exp_rd[d][1]);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (mv[d] !== 1'b0 || mcfg[d] !== 1'b0 || mws[d] !== 4'h0 || mad[d] !== 32'd0
                || mwd[d] !== 32'd0 || gnt[d] !== 2'b00 || bsy[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s_down dut%0d: valid=%b cfg=%b wstrb=%h addr=%h wdata=%h grant=%b busy=%b want all 0",
                         tag, d, mv[d], mcfg[d], mws[d], mad[d], mwd[d], gnt[d], bsy[d]);
            end
            checks++;
            if (rdy[d][0] !== 1'b0 || rdy[d][1] !== 1'b0 || rd[d][0] !== 32'd0 || rd[d][1] !== 32'd0) begin
                errors++;
                $display("FAIL %s_up dut%0d: ready=%b%b rdata=%h %h want 0",
                         tag, d, rdy[d][1], rdy[d][0], rd[d][0], rd[d][1]);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rand_fields();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        model_reset();
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        rand_fields();
        p_addr[0] = 32'h0000_0010;
        p_wstrb[0] = 4'h0;
        do_txn(2'b01, 1'b0, 4, 32'hDEAD_BEEF);
        checks++;
        if (rd[0][0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_read: got %h want deadbeef", rd[0][0]);
        end
    endtask

    task automatic test_write();
        rand_fields();
        p_wstrb[1] = 4'b0011;
        p_wdata[1] = 32'h1234_5678;
        do_txn(2'b10, 1'b0, 3, $urandom);
    endtask

    task automatic test_tie_rr();
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            do_txn(2'b11, 1'b0, $urandom_range(0, 2), $urandom);
        end
    endtask

    task automatic test_tie_fixed();
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            do_txn(2'b11, 1'b0, $urandom_range(0, 2), $urandom);
        end
        rand_fields();
        do_txn(2'b10, 1'b0, 1, $urandom);
    endtask

    task automatic test_stray_ready();
        vld = 2'b00;
        mem_ready = 1'b1;
        repeat (3) begin
            mem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (bsy[d] !== 1'b0 || mv[d] !== 1'b0 || gnt[d] !== 2'b00
                    || rdy[d][0] !== 1'b0 || rdy[d][1] !== 1'b0
                    || rd[d][0] !== exp_rd[d][0] || rd[d][1] !== exp_rd[d][1]) begin
                    errors++;
                    $display("FAIL stray_ready dut%0d: busy=%b valid=%b grant=%b ready=%b%b want idle",
                             d, bsy[d], mv[d], gnt[d], rdy[d][1], rdy[d][0]);
                end
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        rand_fields();
        vld = 2'b11;
        @(posedge clk); @(negedge clk);
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        vld = 2'b00;
        mem_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        mem_ready = 1'b0;
        rand_fields();
        do_txn(2'b11, 1'b0, 1, $urandom);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            rand_fields();
            do_txn(2'($urandom_range(1, 3)), 1'($urandom % 2), $urandom_range(0, 5), $urandom);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy[d][0] === 1'b1 && rdy[d][1] === 1'b1) begin
                    errors++;
                    $display("FAIL both_ready dut%0d: got 11 want at most one", d);
                end
            end
        end
    end

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_tie_rr();
        test_tie_fixed();
        test_stray_ready();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
